// File: rtl/v_alu_pkg.sv
// Shared opcodes and FSM state encodings for the multi-cycle ALU.
package v_alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_XOR  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_MULH = 4'hB;
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_DIVU = 4'hD;
  localparam logic [3:0] ALU_REM  = 4'hE;
  localparam logic [3:0] ALU_REMU = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/v_alu_core.sv
// Combinational single-cycle ALU ops (ADD..SLTU) with ADD/SUB carry and overflow.
module v_alu_core
  import v_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_c,
  output logic             o_v
);
  logic [WIDTH:0]          w_add;
  logic [WIDTH:0]          w_sub;
  logic [SHW-1:0]          w_sh;
  logic signed [WIDTH-1:0] w_as;
  logic signed [WIDTH-1:0] w_bs;

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh  = i_b[SHW-1:0];
  assign w_as  = $signed(i_a);
  assign w_bs  = $signed(i_b);

  always_comb begin
    o_res = '0;
    o_c   = 1'b0;
    o_v   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_res = w_add[WIDTH-1:0];
        o_c   = w_add[WIDTH];
        o_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB: begin
        // C is the inverted borrow, matching the single-cycle ALU
        o_res = w_sub[WIDTH-1:0];
        o_c   = ~w_sub[WIDTH];
        o_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_XOR:  o_res = i_a ^ i_b;
      ALU_OR:   o_res = i_a | i_b;
      ALU_AND:  o_res = i_a & i_b;
      ALU_SLL:  o_res = i_a << w_sh;
      ALU_SRL:  o_res = i_a >> w_sh;
      ALU_SRA:  o_res = w_as >>> w_sh;
      ALU_SLT:  o_res = {{(WIDTH-1){1'b0}}, (w_as < w_bs)};
      ALU_SLTU: o_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default:  o_res = '0;
    endcase
  end
endmodule

// File: rtl/v_alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ops via v_alu_core, iterative
// shift-add multiply and restoring divide sharing one 2*WIDTH accumulator.
module v_alu_mc
  import v_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             busy
);
  localparam int W2 = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // High half of a conditionally negated {hi,lo}: the +1 carries into hi only when lo is 0.
  function automatic logic [WIDTH-1:0] neg_hi(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo, input logic n);
    return n ? (~hi + {{(WIDTH-1){1'b0}}, (lo == '0)}) : hi;
  endfunction

  state_e           r_state, w_state_nx;
  logic             r_vld_p0;
  logic [WIDTH-1:0] r_a_p0, r_b_p0;
  logic [3:0]       r_op_p0;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_dvs;
  logic [SHW-1:0]   r_cnt;
  logic             r_neg, r_neg_a;
  logic [WIDTH-1:0] r_res;
  logic             r_z, r_n, r_c, r_v;

  logic             w_accept, w_is_mul, w_is_div, w_sgn_op, w_b_zero, w_ovf, w_div_spec;
  logic             w_a_neg, w_b_neg, w_last, w_load_res, w_c_nx, w_v_nx;
  logic             w_core_c, w_core_v;
  logic [WIDTH-1:0] w_core_res, w_spec_res, w_iter_res, w_res_nx;
  logic [WIDTH:0]   w_mul_sum, w_shift, w_trial;
  logic [W2-1:0]    w_acc_nx;

  v_alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .i_a   (r_a_p0),
    .i_b   (r_b_p0),
    .i_op  (r_op_p0),
    .o_res (w_core_res),
    .o_c   (w_core_c),
    .o_v   (w_core_v)
  );

  assign in_ready  = rst_n && (r_state == S_IDLE) && !r_vld_p0;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_res;
  assign {Z, N, C, V} = {r_z, r_n, r_c, r_v};

  assign w_is_mul   = (r_op_p0 == ALU_MUL) || (r_op_p0 == ALU_MULH);
  assign w_is_div   = (r_op_p0[3:2] == 2'b11);
  assign w_sgn_op   = (r_op_p0 == ALU_MULH) || (r_op_p0 == ALU_DIV) || (r_op_p0 == ALU_REM);
  assign w_b_zero   = (r_b_p0 == '0);
  assign w_ovf      = ((r_op_p0 == ALU_DIV) || (r_op_p0 == ALU_REM)) &&
                      (r_a_p0 == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b_p0 == '1);
  assign w_div_spec = w_is_div && (w_b_zero || w_ovf);
  assign w_a_neg    = w_sgn_op && r_a_p0[WIDTH-1];
  assign w_b_neg    = w_sgn_op && r_b_p0[WIDTH-1];
  assign w_last     = (r_cnt == SHW'(WIDTH - 1));

  // op[1] separates DIV/DIVU (0) from REM/REMU (1)
  always_comb begin
    w_spec_res = '0;
    if (w_b_zero)         w_spec_res = r_op_p0[1] ? r_a_p0 : '1;
    else if (!r_op_p0[1]) w_spec_res = r_a_p0;
  end

  // Iteration step: multiply shifts right adding the multiplicand, divide shifts left restoring
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
  assign w_shift   = r_acc[W2-1:WIDTH-1];
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_acc_nx  = w_is_mul ? {w_mul_sum, r_acc[WIDTH-1:1]}
                   : (w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1});

  always_comb begin
    case (r_op_p0)
      ALU_MUL:           w_iter_res = w_acc_nx[WIDTH-1:0];
      ALU_MULH:          w_iter_res = neg_hi(w_acc_nx[W2-1:WIDTH], w_acc_nx[WIDTH-1:0], r_neg);
      ALU_DIV, ALU_DIVU: w_iter_res = cond_neg(w_acc_nx[WIDTH-1:0], r_neg);
      ALU_REM, ALU_REMU: w_iter_res = cond_neg(w_acc_nx[W2-1:WIDTH], r_neg_a);
      default:           w_iter_res = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_load_res = 1'b0;
    w_res_nx   = '0;
    w_c_nx     = 1'b0;
    w_v_nx     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_vld_p0) begin
          w_load_res = !(w_is_mul || (w_is_div && !w_div_spec));
          w_state_nx = w_load_res ? S_DONE : S_EXEC;
          w_res_nx   = w_div_spec ? w_spec_res : w_core_res;
          w_c_nx     = w_core_c;
          w_v_nx     = w_core_v;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_state_nx = S_DONE;
          w_load_res = 1'b1;
          w_res_nx   = w_iter_res;
        end
      end
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_vld_p0 <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      {r_z, r_n, r_c, r_v} <= 4'b0;
    end else begin
      r_state  <= w_state_nx;
      r_vld_p0 <= w_accept;
      r_cnt    <= (r_state == S_EXEC) ? r_cnt + SHW'(1) : '0;
      if (w_load_res) begin
        r_res <= w_res_nx;
        r_z   <= (w_res_nx == '0);
        r_n   <= w_res_nx[WIDTH-1];
        r_c   <= w_c_nx;
        r_v   <= w_v_nx;
      end
    end
  end

  // Stage p0: operand capture; EXEC loads magnitudes then iterates in place
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p0  <= A;
      r_b_p0  <= B;
      r_op_p0 <= alu_op;
    end
    if ((r_state == S_IDLE) && r_vld_p0) begin
      r_acc   <= {{WIDTH{1'b0}}, cond_neg(r_a_p0, w_a_neg)};
      r_dvs   <= cond_neg(r_b_p0, w_b_neg);
      r_neg   <= w_a_neg ^ w_b_neg;
      r_neg_a <= w_a_neg;
    end else if (r_state == S_EXEC) begin
      r_acc   <= w_acc_nx;
    end
  end
endmodule

// File: tb/tb_v_alu_mc.sv
// Scoreboard bench for v_alu_mc at WIDTH=32 and WIDTH=8.
module tb_v_alu_mc;
  import v_alu_pkg::*;

  typedef struct {
    int          inst;
    logic [31:0] res;
    logic [3:0]  flg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic prev_ov [2];

  logic        iv32 = 0, or32 = 1, ir32, ov32, z32, n32, c32, v32, bsy32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  logic [3:0]  op32 = 0;
  logic        iv8 = 0, or8 = 1, ir8, ov8, z8, n8, c8, v8, bsy8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic [3:0]  op8 = 0;

  v_alu_mc #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .alu_op(op32), .out_valid(ov32), .out_ready(or32), .result(res32),
    .Z(z32), .N(n32), .C(c32), .V(v32), .busy(bsy32));

  v_alu_mc #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .alu_op(op8), .out_valid(ov8), .out_ready(or8), .result(res8),
    .Z(z8), .N(n8), .C(c8), .V(v8), .busy(bsy8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int i);
    logic ov, rdy_o;
    logic [31:0] r;
    logic [3:0] f;
    exp_t e;
    if (i == 0) begin
      ov = ov32; rdy_o = or32; r = res32; f = {z32, n32, c32, v32};
    end else begin
      ov = ov8; rdy_o = or8; r = {24'h0, res8}; f = {z8, n8, c8, v8};
    end
    if (ov && !prev_ov[i]) begin
      if (q.size() == 0 || q[0].inst != i) chk("spurious_valid", {31'h0, ov}, 32'h0);
      else chk("latency", cyc, q[0].due);
    end
    if (ov && rdy_o && q.size() != 0 && q[0].inst == i) begin
      e = q.pop_front();
      chk("result", r, e.res);
      chk("flags_ZNCV", {28'h0, f}, {28'h0, e.flg});
    end
    prev_ov[i] = ov;
  endtask

  initial begin
    prev_ov[0] = 1'b0;
    prev_ov[1] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      mon_one(0);
      mon_one(1);
    end
  end

  task automatic issue(input int inst, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                       input int lat);
    exp_t e;
    int t;
    @(negedge clk);
    if (inst == 0) begin
      a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; iv8 = 1'b1;
    end
    t = 0;
    while (!(inst == 0 ? ir32 : ir8) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("accept_timeout", {31'h0, (inst == 0 ? ir32 : ir8)}, 32'h1);
      iv32 = 1'b0; iv8 = 1'b0;
      return;
    end
    e.inst = inst; e.res = er; e.flg = ef; e.due = cyc + 1 + lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    iv32 = 1'b0; iv8 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    #3;
    chk("rst_result", res32, 32'h0);
    chk("rst_out_valid", {31'h0, ov32}, 32'h0);
    chk("rst_busy", {31'h0, bsy32}, 32'h0);
    chk("rst_in_ready", {31'h0, ir32}, 32'h0);
    chk("rst_flags", {28'h0, z32, n32, c32, v32}, 32'h0);
    chk("rst_result8", {24'h0, res8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, ALU_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 4'b1010, 1);
    @(posedge clk); #1;
    chk("in_ready_low_in_done", {31'h0, ir32}, 32'h0);
    issue(0, ALU_SUB,  32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 1);
    issue(0, ALU_ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101, 1);
    issue(0, ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1);
    issue(0, ALU_OR,   32'h12, 32'h21, 32'h33, 4'b0000, 1);
    issue(0, ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 4'b1000, 1);
    issue(0, ALU_SLL,  32'h1, 32'd35, 32'h8, 4'b0000, 1);
    issue(0, ALU_SRL,  32'h80000000, 32'd4, 32'h08000000, 4'b0000, 1);
    issue(0, ALU_SRA,  32'h80000000, 32'd4, 32'hF8000000, 4'b0100, 1);
    issue(0, ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000, 1);
    issue(0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1000, 1);
    issue(0, ALU_MUL,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 4'b0100, 33);
    issue(0, ALU_MULH, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 4'b0100, 33);
    issue(0, ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33);
    issue(0, ALU_DIV,  32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, 33);
    issue(0, ALU_REM,  32'h7, 32'hFFFFFFFE, 32'h1, 4'b0000, 33);
    issue(0, ALU_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 4'b0100, 33);
    issue(0, ALU_REM,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 4'b0100, 33);
    issue(0, ALU_DIVU, 32'hFFFFFFFF, 32'h2, 32'h7FFFFFFF, 4'b0000, 33);
    issue(0, ALU_DIVU, 32'h5, 32'h0, 32'hFFFFFFFF, 4'b0100, 1);
    issue(0, ALU_REMU, 32'h5, 32'h0, 32'h5, 4'b0000, 1);
    issue(0, ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 1);
    issue(0, ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 4'b1000, 1);
    drain();

    // Backpressure on a long divide
    or32 = 1'b0;
    issue(0, ALU_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
    for (int t = 0; t < 60 && !ov32; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_result_held", res32, 32'd14);
      chk("bp_in_ready_low", {31'h0, ir32}, 32'h0);
      chk("bp_out_valid_held", {31'h0, ov32}, 32'h1);
    end
    @(negedge clk);
    or32 = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready_after_release", {31'h0, ir32}, 32'h1);
    drain();

    // Reset in the middle of a divide
    issue(0, ALU_DIV, 32'd100, 32'd3, 32'd33, 4'b0000, 33);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", {31'h0, ov32}, 32'h0);
    chk("mid_rst_busy", {31'h0, bsy32}, 32'h0);
    chk("mid_rst_result", res32, 32'h0);
    chk("mid_rst_in_ready", {31'h0, ir32}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, ALU_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
    drain();

    issue(1, ALU_MUL,  32'h10, 32'h10, 32'h00, 4'b1000, 9);
    issue(1, ALU_MULH, 32'h10, 32'h10, 32'h01, 4'b0000, 9);
    issue(1, ALU_SRA,  32'h80, 32'h3, 32'hF0, 4'b0100, 1);
    issue(1, ALU_ADD,  32'hFF, 32'h1, 32'h00, 4'b1010, 1);
    issue(1, ALU_DIV,  32'h80, 32'hFF, 32'h80, 4'b0100, 1);
    issue(1, ALU_DIVU, 32'hC8, 32'h7, 32'h1C, 4'b0000, 9);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
